sram_readback_checker: RTL and testbench
========================================

# sram_readback_checker

Bit-serial SRAM read-back engine for the BNN test harness: walks an address range of the BNN weight SRAM, drives the read-side SRAM controls (SRAMA/SRAMCEN/SRAMWEN), samples the 1-bit SRAMDOUT, and compares every bit against the same LFSR pattern the write sequencer uses to load the SRAM. It is the reader counterpart of the serial write sequencer. It sits beside that sequencer on the sysclk domain and reports pass/fail, error count and first failing address to the FPGA-side status logic.

## Interface
- ADDR_W, 13, SRAM bit-address width
- READ_LAT, 2, cycles from address/CEN presented to SRAMDOUT valid (≥1)
- SEED, 16'hACE1, LFSR seed; identical to the write sequencer's seed
- ERR_W, 16, error-counter width

- sysclk  in  1  single clock, all logic rising-edge
- RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first address, sampled with start
- num_bits  in  ADDR_W+1  bits to check, sampled with start; 0 = empty run
- SRAMA  out  ADDR_W  read address to SRAM
- SRAMCEN  out  1  chip enable, active-low
- SRAMWEN  out  1  write enable, active-low; constant 1 (read only)
- SRAMDOUT  in  1  SRAM read data bit
- busy  out  1  run in progress
- done  out  1  one-cycle pulse, results valid
- err_cnt  out  ERR_W  mismatches, saturating at all-ones
- first_err_addr  out  ADDR_W  address of first mismatch
- first_err_valid  out  1  at least one mismatch recorded
- pass  out  1  last run finished with err_cnt == 0

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, loaded with SEED on start; expected bit = lfsr[0]; advances once per compared bit, never per issued address.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: SRAMCEN=1. On start: latch base_addr/num_bits, clear err_cnt, first_err_*, pass, reload LFSR; go ISSUE (num_bits≠0) or DONE (num_bits=0).
  - ISSUE: each cycle drive SRAMA=base+i (mod 2^ADDR_W, wraps silently), SRAMCEN=0; push {valid, addr} into a READ_LAT-deep pipeline. After issuing index num_bits-1 go DRAIN.
  - DRAIN: SRAMCEN=1, SRAMA holds last value; wait until the pipeline is empty, then DONE.
  - DONE: done=1, pass=(err_cnt==0), busy=0; next cycle IDLE.
- Compare: when pipeline output valid, mismatch if SRAMDOUT≠lfsr[0]; err_cnt+1 (saturating); on first mismatch latch pipeline address into first_err_addr and set first_err_valid. Later mismatches do not overwrite the address.
- start while busy or in DONE: ignored. Results hold after done until the next accepted start.
- RST at any time: all state to reset values on the next edge, run aborted, no done pulse.
- Reset values: SRAMA=0, SRAMCEN=1, SRAMWEN=1, busy=0, done=0, err_cnt=0, first_err_addr=0, first_err_valid=0, pass=0; FSM IDLE; pipeline valids cleared.

## Timing
- Cycle 0: start sampled high in IDLE.
- Address k (0≤k<N) on SRAMA with SRAMCEN=0 at cycle 1+k; busy high from cycle 1.
- SRAMDOUT for address k sampled at cycle 1+k+READ_LAT.
- Last sample at cycle N+READ_LAT; err_cnt/first_err_* updated the following edge.
- done high, busy low, all results final at cycle N+READ_LAT+1; IDLE at N+READ_LAT+2, earliest next start sampled there.
- N=0: done at cycle 1, pass=1, err_cnt=0, SRAMCEN never low.
- Throughput: one bit per cycle, no bubbles; SRAMCEN low for exactly N consecutive cycles.

## Test plan
- SRAM model preloaded with LFSR(SEED) from addr 100, start base=100 N=64, READ_LAT=2 -> SRAMCEN low cycles 1..64, done at cycle 67, err_cnt=0, pass=1, first_err_valid=0.
- Same preload with bits at addrs 110 and 140 flipped -> err_cnt=2, first_err_addr=110, first_err_valid=1, pass=0.
- base=8190, N=4 -> SRAMA sequence 8190, 8191, 0, 1; comparisons use wrapped addresses; first_err_addr reports the wrapped value.
- num_bits=0 -> done at cycle 1, pass=1, no SRAMCEN activity; start pulses mid-run (cycle 10 of N=64) -> ignored, done still at cycle 67.
- RST asserted at cycle 20 of N=64 run -> next cycle all outputs at reset values, SRAMCEN=1, no done; fresh start afterwards completes normally.
- Model returning all-inverted data, N=2^ERR_W+5 with ERR_W=4 -> err_cnt saturates at 15, first_err_addr=base.

Source files
------------

// File: rtl/sram_readback_checker.sv
// Bit-serial SRAM read-back checker: walks an address range, compares
// each returned bit against the write-side LFSR pattern, reports errors.
module sram_readback_checker #(
   parameter int          ADDR_W   = 13,
   parameter int          READ_LAT = 2,
   parameter logic [15:0] SEED     = 16'hACE1,
   parameter int          ERR_W    = 16
) (
   input  logic              sysclk,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   num_bits,
   output logic [ADDR_W-1:0] SRAMA,
   output logic              SRAMCEN,
   output logic              SRAMWEN,
   input  logic              SRAMDOUT,
   output logic              busy,
   output logic              done,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              first_err_valid,
   output logic              pass
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [ADDR_W:0]   num_q;
   logic [ADDR_W:0]   idx_q;
   logic [ADDR_W-1:0] a_q;
   logic              cen_q;
   logic [15:0]       lfsr_q;
   logic [ERR_W-1:0]  err_q;
   logic [ADDR_W-1:0] fa_q;
   logic              fv_q;
   logic              pass_q;

   logic [READ_LAT-1:0] pv_q;
   logic [ADDR_W-1:0]   pa_q [READ_LAT];

   logic accept;
   logic last_issue;
   logic drain_ok;
   logic cmp_v;
   logic mism;

   assign last_issue = (idx_q == (num_q - 1'b1));
   assign cmp_v      = pv_q[READ_LAT-1];
   assign mism       = cmp_v && (SRAMDOUT != lfsr_q[0]);

   always_ff @(posedge sysclk) begin
      if (RST) state <= IDLE;
      else     state <= state_nx;
   end

   // Drain ends on the edge that consumes the last in-flight entry.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      drain_ok = 1'b1;
      for (int i = 0; i < READ_LAT - 1; i++) begin
         if (pv_q[i]) drain_ok = 1'b0;
      end
      case (state)
         IDLE: begin
            if (start) begin
               accept   = 1'b1;
               state_nx = (num_bits == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: if (last_issue) state_nx = DRAIN;
         DRAIN: if (drain_ok) state_nx = DONE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (RST) begin
         num_q  <= '0;
         idx_q  <= '0;
         a_q    <= '0;
         cen_q  <= 1'b1;
         lfsr_q <= SEED;
         err_q  <= '0;
         fa_q   <= '0;
         fv_q   <= 1'b0;
         pass_q <= 1'b0;
         pv_q   <= '0;
         for (int i = 0; i < READ_LAT; i++) pa_q[i] <= '0;
      end else begin
         pv_q[0] <= ~cen_q;
         pa_q[0] <= a_q;
         for (int i = 1; i < READ_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pa_q[i] <= pa_q[i-1];
         end
         if (accept) begin
            num_q  <= num_bits;
            idx_q  <= '0;
            a_q    <= base_addr;
            cen_q  <= (num_bits == '0);
            lfsr_q <= SEED;
            err_q  <= '0;
            fa_q   <= '0;
            fv_q   <= 1'b0;
            pass_q <= 1'b0;
         end else begin
            if (state == ISSUE) begin
               if (last_issue) begin
                  cen_q <= 1'b1;
               end else begin
                  a_q   <= a_q + 1'b1;
                  idx_q <= idx_q + 1'b1;
               end
            end
            if (cmp_v) begin
               lfsr_q <= {1'b0, lfsr_q[15:1]}
                       ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            end
            if (mism) begin
               if (err_q != '1) err_q <= err_q + 1'b1;
               if (!fv_q) begin
                  fa_q <= pa_q[READ_LAT-1];
                  fv_q <= 1'b1;
               end
            end
            if (state == DONE) pass_q <= (err_q == '0);
         end
      end
   end

   assign SRAMA           = a_q;
   assign SRAMCEN         = cen_q;
   assign SRAMWEN         = 1'b1;
   assign busy            = (state == ISSUE) || (state == DRAIN);
   assign done            = (state == DONE);
   assign err_cnt         = err_q;
   assign first_err_addr  = fa_q;
   assign first_err_valid = fv_q;
   assign pass = (state == DONE) ? (err_q == '0) : pass_q;

endmodule

// File: tb/tb_sram_readback_checker.sv
// Randomised and directed bench for sram_readback_checker against
// an SRAM model and a run-level reference of the expected results.
module tb_sram_readback_checker;

   localparam int AW   = 13;
   localparam int L    = 2;
   localparam int EW   = 4;
   localparam int MSZ  = 1 << AW;
   localparam int EMAX = (1 << EW) - 1;
   localparam logic [15:0] SD = 16'hACE1;

   logic          clk = 1'b0;
   logic          RST;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   num_bits;
   logic [AW-1:0] SRAMA;
   logic          SRAMCEN;
   logic          SRAMWEN;
   logic          SRAMDOUT;
   logic          busy;
   logic          done;
   logic [EW-1:0] err_cnt;
   logic [AW-1:0] first_err_addr;
   logic          first_err_valid;
   logic          pass;

   int total = 0;
   int bad   = 0;

   logic mem [MSZ];
   logic inv = 1'b0;
   logic rd [L];

   always #5 clk = ~clk;

   sram_readback_checker #(
      .ADDR_W(AW), .READ_LAT(L), .SEED(SD), .ERR_W(EW)
   ) dut (
      .sysclk(clk), .RST(RST), .start(start),
      .base_addr(base_addr), .num_bits(num_bits),
      .SRAMA(SRAMA), .SRAMCEN(SRAMCEN), .SRAMWEN(SRAMWEN),
      .SRAMDOUT(SRAMDOUT), .busy(busy), .done(done),
      .err_cnt(err_cnt), .first_err_addr(first_err_addr),
      .first_err_valid(first_err_valid), .pass(pass)
   );

   always @(posedge clk) begin
      rd[0] <= !SRAMCEN ? (mem[SRAMA] ^ inv) : 1'b0;
      for (int i = 1; i < L; i++) rd[i] <= rd[i-1];
   end
   assign SRAMDOUT = rd[L-1];

   task automatic chk(input string tag,
                      input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] nxt(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic fill(input int base, input int n);
      logic [15:0] l = SD;
      for (int k = 0; k < n; k++) begin
         mem[(base + k) % MSZ] = l[0];
         l = nxt(l);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_a"}, int'(SRAMA), 0);
      chk({tag, "_cen"}, int'(SRAMCEN), 1);
      chk({tag, "_wen"}, int'(SRAMWEN), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_err"}, int'(err_cnt), 0);
      chk({tag, "_fa"}, int'(first_err_addr), 0);
      chk({tag, "_fv"}, int'(first_err_valid), 0);
      chk({tag, "_pass"}, int'(pass), 0);
   endtask

   task automatic run(input string tag, input int base,
                      input int n, input int mid, input int rst_at);
      logic [15:0] l = SD;
      int ee = 0;
      int efa = 0;
      bit efv = 0;
      int c, k, abad, done_c, nd;
      for (int j = 0; j < n; j++) begin
         int a = (base + j) % MSZ;
         if ((mem[a] ^ inv) != l[0]) begin
            if (ee < EMAX) ee++;
            if (!efv) begin
               efv = 1;
               efa = a;
            end
         end
         l = nxt(l);
      end
      @(posedge clk); #1;
      base_addr = AW'(base);
      num_bits  = (AW+1)'(n);
      start     = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      c      = 1;
      k      = 0;
      abad   = 0;
      done_c = -1;
      while (c < n + L + 20) begin
         if (!SRAMCEN) begin
            if (int'(SRAMA) != (base + k) % MSZ || c != 1 + k)
               abad++;
            k++;
         end
         if (done) begin
            done_c = c;
            break;
         end
         if (c == rst_at) begin
            RST = 1'b1;
            @(posedge clk); #1;
            RST = 1'b0;
            check_reset_vals({tag, "_rst"});
            nd = 0;
            for (int i = 0; i < n + L + 5; i++) begin
               if (done || !SRAMCEN) nd++;
               @(posedge clk); #1;
            end
            chk({tag, "_nodone"}, nd, 0);
            return;
         end
         start = (c == mid);
         if (c == mid) base_addr = ~base_addr;
         @(posedge clk); #1;
         start = 1'b0;
         c++;
      end
      chk({tag, "_donecyc"}, done_c, (n == 0) ? 1 : n + L + 1);
      chk({tag, "_cencnt"}, k, n);
      chk({tag, "_addrseq"}, abad, 0);
      chk({tag, "_err"}, int'(err_cnt), ee);
      chk({tag, "_fv"}, int'(first_err_valid), int'(efv));
      if (efv) chk({tag, "_fa"}, int'(first_err_addr), efa);
      chk({tag, "_pass"}, int'(pass), int'(ee == 0));
      chk({tag, "_busy"}, int'(busy), 0);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, int'(done), 0);
      chk({tag, "_hold"}, int'(pass), int'(ee == 0));
      chk({tag, "_herr"}, int'(err_cnt), ee);
   endtask

   initial begin
      RST       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      num_bits  = '0;
      for (int i = 0; i < MSZ; i++) mem[i] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("reset");
      RST = 1'b0;

      fill(100, 64);
      run("clean", 100, 64, -1, -1);
      mem[110] = ~mem[110];
      mem[140] = ~mem[140];
      run("flip2", 100, 64, -1, -1);
      fill(100, 64);
      run("midstart", 100, 64, 10, -1);

      fill(8190, 4);
      mem[0] = ~mem[0];
      run("wrap", 8190, 4, -1, -1);
      run("empty", 0, 0, -1, -1);
      fill(100, 64);
      run("abort", 100, 64, -1, 20);
      run("after_rst", 100, 64, -1, -1);

      fill(300, 21);
      inv = 1'b1;
      run("sat", 300, 21, -1, -1);
      inv = 1'b0;

      for (int r = 0; r < 8; r++) begin
         int b = $urandom_range(0, MSZ - 1);
         int n = $urandom_range(0, 300);
         int nf = $urandom_range(0, 5);
         fill(b, n);
         if (n > 0) begin
            for (int f = 0; f < nf; f++) begin
               int a = (b + $urandom_range(0, n - 1)) % MSZ;
               mem[a] = ~mem[a];
            end
         end
         run($sformatf("rnd%0d", r), b, n, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
